// File: rtl/sha256_msg_rx.sv
// UART 8N1 receiver that collects one CR/LF-terminated line (up to 55 bytes)
// and presents it as a fully padded single SHA-256 block, msg[0:7] = first byte.
module sha256_msg_rx #(
  parameter int CLKS_PER_BIT = 520
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rxd,
  input  logic         msg_ready,
  output logic [0:511] msg,
  output logic         msg_valid,
  output logic [5:0]   msg_len,
  output logic         overflow,
  output logic         frame_err
);

  localparam int          MAX_BYTES = 55;
  localparam logic [5:0]  MAX_CNT   = 6'(MAX_BYTES);
  localparam int          CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

  logic      rxd_meta_q, rxd_s_q;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_stb_q, byte_stb_d;
  logic       frame_err_q, frame_err_d;

  logic [5:0]               count_q, count_d;
  logic [0:MAX_BYTES*8-1]   buf_q, buf_d;
  logic [0:511]             msg_q, msg_d;
  logic                     msg_valid_q, msg_valid_d;
  logic [5:0]               msg_len_q, msg_len_d;
  logic                     overflow_q, overflow_d;

  logic [8:0]   byte_base;
  logic [0:447] data_ext;
  logic [0:511] pad_blk;
  logic         is_term;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;  // high at mid start bit is a glitch
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          state_d     = S_IDLE;
          byte_stb_d  = rxd_s_q;
          frame_err_d = !rxd_s_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bytes past count are always zero, so the marker only needs to be dropped in.
  always_comb begin
    byte_base = {count_q, 3'b000};
    data_ext  = {buf_q, 8'h00};
    data_ext[byte_base +: 8] = 8'h80;
    pad_blk   = {data_ext, {55'd0, count_q, 3'b000}};
  end

  assign is_term = (shift_q == 8'h0D) || (shift_q == 8'h0A);

  always_comb begin
    count_d     = count_q;
    buf_d       = buf_q;
    msg_d       = msg_q;
    msg_valid_d = msg_valid_q;
    msg_len_d   = msg_len_q;
    overflow_d  = 1'b0;
    if (msg_valid_q && msg_ready) begin
      msg_valid_d = 1'b0;
      count_d     = '0;
      buf_d       = '0;
    end
    if (byte_stb_q) begin
      if (msg_valid_q) begin
        overflow_d = 1'b1;  // still 1 even in the accepting cycle
      end else if (is_term) begin
        if (count_q != 6'd0) begin
          msg_valid_d = 1'b1;
          msg_d       = pad_blk;
          msg_len_d   = count_q;
        end
      end else if (count_q < MAX_CNT) begin
        buf_d[byte_base +: 8] = shift_q;
        count_d = count_q + 6'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
      count_q     <= '0;
      // NOTE: the byte buffer is reset because the padding logic relies on unused bytes being zero.
      buf_q       <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      msg_len_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
      count_q     <= count_d;
      buf_q       <= buf_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      msg_len_q   <= msg_len_d;
      overflow_q  <= overflow_d;
    end
  end

  assign msg       = msg_q;
  assign msg_valid = msg_valid_q;
  assign msg_len   = msg_len_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sha256_msg_rx.sv
// Self-checking bench for sha256_msg_rx: directed line scenarios plus random
// lines, compared against a byte-queue model of the padded block.
module tb_sha256_msg_rx;

  localparam int CPB = 8;
  // Terminator's msg_valid rises on this negedge counted from the start-bit drive:
  // 2 sync flops + 1 idle cycle + half bit + 9 bit periods + 1 registered strobe.
  localparam int VALID_AT = 4 + CPB / 2 + 9 * CPB;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rxd = 1'b1;
  logic         msg_ready = 1'b0;
  logic [0:511] msg;
  logic         msg_valid;
  logic [5:0]   msg_len;
  logic         overflow;
  logic         frame_err;

  always #5 clk = ~clk;

  sha256_msg_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .msg_ready (msg_ready),
    .msg       (msg),
    .msg_valid (msg_valid),
    .msg_len   (msg_len),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  int errors = 0;
  int checks = 0;

  int   ovf_seen = 0;
  int   ferr_seen = 0;
  int   valid_rises = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_seen++;
    if (frame_err === 1'b1) ferr_seen++;
    if (msg_valid === 1'b1 && valid_prev !== 1'b1) valid_rises++;
    valid_prev = msg_valid;
  end

  // Reference model state
  logic [7:0]   cur[$];
  bit           pend = 1'b0;
  logic [511:0] exp_blk = '0;
  int           exp_len = 0;
  int           exp_ovf = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pad(input logic [7:0] b[$]);
    logic [511:0] r = '0;
    int n = b.size();
    for (int i = 0; i < n; i++) r[511 - 8 * i -: 8] = b[i];
    r[511 - 8 * n] = 1'b1;
    r[63:0] = 64'(8 * n);
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit good,
                           output logic vb, output logic va);
    logic [9:0] frame;
    int k;
    frame = {1'b1, b, 1'b0};
    k = 0;
    vb = 1'b0;
    va = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        rxd = (i == 9 && !good) ? (c >= CPB / 2 + 2) : frame[i];
        @(negedge clk);
        k++;
        if (k == VALID_AT - 1) vb = msg_valid;
        if (k == VALID_AT)     va = msg_valid;
      end
    end
    rxd = 1'b1;
  endtask

  task automatic rx(input logic [7:0] b);
    logic vb, va;
    send_byte(b, 1'b1, vb, va);
    if (pend) begin
      exp_ovf++;
      check("held_msg", msg, exp_blk);
    end else if (b == 8'h0A || b == 8'h0D) begin
      if (cur.size() > 0) begin
        pend    = 1'b1;
        exp_blk = pad(cur);
        exp_len = cur.size();
        check("valid_before_latency", vb, 1'b0);
        check("valid_at_latency", va, 1'b1);
        check("msg", msg, exp_blk);
        check("msg_len", msg_len, exp_len);
      end
    end else if (cur.size() < 55) begin
      cur.push_back(b);
    end else begin
      exp_ovf++;
    end
  endtask

  task automatic rx_str(input string s);
    for (int i = 0; i < s.len(); i++) rx(s[i]);
  endtask

  task automatic accept();
    msg_ready = 1'b1;
    @(negedge clk);
    check("accept_drops_valid", msg_valid, 1'b0);
    msg_ready = 1'b0;
    pend = 1'b0;
    cur.delete();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_msg"}, msg, '0);
    check({tag, "_valid"}, msg_valid, 1'b0);
    check({tag, "_len"}, msg_len, '0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
  endtask

  initial begin
    logic vb, va;
    int   base;
    int   n;

    @(negedge clk);
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_valid", msg_valid, 1'b0);

    // "abc" + LF
    rx_str("abc\n");
    check("abc_word0", msg[0:31], 32'h61626380);
    check("abc_zero", msg[32:447], '0);
    check("abc_length", msg[448:511], 64'h18);
    check("abc_len", msg_len, 6'd3);
    accept();

    // bare CRLF gives nothing; "x" CR LF gives exactly one message
    base = valid_rises;
    rx(8'h0D);
    rx(8'h0A);
    settle();
    check("crlf_no_valid", msg_valid, 1'b0);
    rx_str("x\r\n");
    check("x_word", msg[0:15], 16'h7880);
    check("x_length", msg[448:511], 64'h8);
    check("x_len", msg_len, 6'd1);
    settle();
    check("x_one_valid", valid_rises - base, 1);
    accept();

    // 56 data bytes: last one dropped
    base = ovf_seen;
    for (int i = 0; i < 56; i++) rx(8'h61);
    settle();
    check("trunc_one_ovf", ovf_seen - base, 1);
    rx(8'h0A);
    check("trunc_len", msg_len, 6'd55);
    check("trunc_marker", msg[440:447], 8'h80);
    check("trunc_length", msg[448:511], 64'h1B8);
    accept();

    // byte while holding an unaccepted message
    rx_str("hi\n");
    base = ovf_seen;
    rx("q");
    settle();
    check("hold_ovf", ovf_seen - base, 1);
    check("hold_valid", msg_valid, 1'b1);
    check("hold_len", msg_len, 6'd2);
    accept();
    rx_str("z\n");
    check("after_accept_len", msg_len, 6'd1);
    accept();

    // bad stop bit, then a short glitch
    rx("m");
    base = ferr_seen;
    send_byte("Z", 1'b0, vb, va);
    settle();
    check("ferr_one_clk", ferr_seen - base, 1);
    repeat (2 * CPB) @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_ferr", ferr_seen - base, 1);
    check("glitch_no_valid", msg_valid, 1'b0);
    rx_str("n\n");
    accept();

    // reset in the middle of the second byte of "ab\n"
    rx("a");
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b0;  // 'b' bit0
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;  // 'b' bit1
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("mid_reset");
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_zero_outputs("held_reset");
    reset = 1'b1;
    cur.delete();
    pend = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_str("c\n");
    check("reset_word", msg[0:15], 16'h6380);
    check("reset_len", msg_len, 6'd1);
    accept();

    // random lines
    for (int m = 0; m < 4; m++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) rx(8'($urandom_range(8'h20, 8'hFF)));
      rx(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
      accept();
    end

    settle();
    check("total_ovf", ovf_seen, exp_ovf);
    check("total_ferr", ferr_seen, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_rx.md
Name: sha256_msg_rx

Overview:
UART receive front end for the SHA-256 core. It deserialises 8N1 ASCII bytes from RXD and collects one line of up to 55 bytes, ended by CR or LF. It then presents that line as a fully padded single 512-bit SHA-256 block on the same M[0:511] bit ordering the hash core consumes. It is the inbound counterpart of the existing hex-digest UART transmit path, and replaces the hard-coded "abc" message in top.

Parameters:
CLKS_PER_BIT, 520, clock cycles per UART bit (60 MHz / 115200); must be >= 4
MAX_BYTES, 55, largest message that fits one padded block; fixed, not meant to be overridden

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rxd  input  1  UART serial input, idle high, asynchronous to clk
msg_ready  input  1  consumer accepts msg this cycle
msg  output  512 [0:511]  padded SHA-256 block, big-endian, msg[0:7] is the first byte
msg_valid  output  1  msg holds a complete block
msg_len  output  6  byte count of the current message (0..55)
overflow  output  1  one-cycle pulse per dropped data byte
frame_err  output  1  one-cycle pulse per byte with a bad stop bit

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - RX FSM goes to IDLE; synchroniser flops go to 1.
  - Byte buffer and count go to 0.
  - Outputs: msg=0, msg_valid=0, msg_len=0, overflow=0, frame_err=0.
  - Reset mid-frame or mid-message aborts it; no partial output.
- rxd passes through a 2-flop synchroniser (rxd_s); all sampling uses rxd_s.
- RX FSM:
  - IDLE: wait for rxd_s=0, then go to START with the bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles (mid start bit). If rxd_s=1 (glitch), go to IDLE with no output. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample one CLKS_PER_BIT later. rxd_s=1 gives a one-cycle internal byte strobe. rxd_s=0 pulses frame_err for one cycle and drops the byte. Both cases return to IDLE.
- Assembly, on each byte strobe:
  - Byte is 0x0D or 0x0A and count=0: ignored. This lets CRLF produce no empty message.
  - Byte is 0x0D or 0x0A and count>0: finalise. On the next edge, register msg and msg_len and assert msg_valid.
  - Other byte, count<55: store at buf[count*8 +: 8] and increment count.
  - Other byte, count=55: drop it and pulse overflow. The message stays truncated at 55 bytes and finalises normally on the terminator.
  - Any byte arriving while msg_valid=1: drop it and pulse overflow. The receiver FSM keeps running.
- Padding, with n = count and L = 8n:
  - msg[0 +: L] = data bytes.
  - msg[L] = 1.
  - msg[L+1 : 447] = 0.
  - msg[448:511] = L as a 64-bit big-endian value.
- Handshake:
  - msg, msg_len and msg_valid hold stable while msg_valid=1.
  - msg_valid=1 with msg_ready=1 on an edge clears msg_valid and resets count to 0 on that edge.
  - msg_ready is ignored while msg_valid=0.
- Latency: msg_valid rises exactly 1 clk after the terminator byte's stop-bit sample edge.
- Simultaneous events: a byte strobe in the same cycle as the accepting handshake is dropped with overflow, because msg_valid was still 1 in that cycle.
- overflow and frame_err are pulses, never sticky.

Test Plan:
1. CLKS_PER_BIT=8; send 0x61 0x62 0x63 0x0A → msg_valid=1 one clk after the LF stop sample. msg[0:31]=0x61626380, msg[32:447]=0, msg[448:511]=0x18, msg_len=3. Feeding msg to sha256 gives hash=ba7816bf...f20015ad.
2. Send 0x0D 0x0A, then "x" 0x0D 0x0A → exactly one msg_valid. msg[0:15]=0x7880, length field 0x08, msg_len=1.
3. Send 56 bytes 0x61 then 0x0A → one overflow pulse on byte 56. msg_len=55, msg[440:447]=0x80, msg[448:511]=0x1B8.
4. Hold msg_ready=0 after finalisation and send "q" → overflow pulses, msg unchanged. Assert msg_ready → msg_valid drops on that edge, msg_len returns to 0 internally.
5. Byte with stop bit driven 0 → frame_err high for exactly 1 clk, byte absent from msg. A 2-clk low glitch on rxd → no byte and no error.
6. Assert reset mid-data-bit of byte 2 of "ab\n", release, send "c\n" → msg[0:15]=0x6380, msg_len=1, all outputs 0 while reset was held.
